// File: rtl/serial_mod_n.sv
// Serial divisibility checker: tracks the remainder of an incoming bitstream modulo a
// runtime-selected N, in MSB-first or LSB-first order, one bit per clock.
module serial_mod_n #(
    parameter int unsigned MOD_W = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [MOD_W-1:0] mod_in,
    input  logic             lsb_first,
    input  logic             in,
    input  logic             in_valid,
    output logic             out,
    output logic [MOD_W-1:0] rem,
    output logic [CNT_W-1:0] bit_count,
    output logic             busy,
    output logic             err
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StErr  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [MOD_W-1:0] n_q, n_d;
    logic [MOD_W-1:0] rem_q, rem_d;
    logic [MOD_W-1:0] wt_q, wt_d;
    logic             lsb_q, lsb_d;
    logic             out_q, out_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [MOD_W-1:0] op_rem, op_wt, op_n, wt_init, rem_step, wt_step;
    logic             op_lsb;
    logic [MOD_W:0]   t, u, n_ext;

    // Step operands come from the cleared frame on a start cycle so that a bit
    // accepted alongside start is processed against remainder 0.
    always_comb begin
        wt_init = (mod_in == MOD_W'(1)) ? '0 : MOD_W'(1);
        if (start) begin
            op_rem = '0;
            op_wt  = wt_init;
            op_n   = mod_in;
            op_lsb = lsb_first;
        end else begin
            op_rem = rem_q;
            op_wt  = wt_q;
            op_n   = n_q;
            op_lsb = lsb_q;
        end

        n_ext = {1'b0, op_n};
        if (op_lsb) begin
            t = {1'b0, op_rem} + (in ? {1'b0, op_wt} : '0);
        end else begin
            t = {op_rem, in};
        end
        // rem and weight are both < N, so one conditional subtract reduces them.
        rem_step = (t >= n_ext) ? MOD_W'(t - n_ext) : t[MOD_W-1:0];
        u        = {op_wt, 1'b0};
        wt_step  = (u >= n_ext) ? MOD_W'(u - n_ext) : u[MOD_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        rem_d   = rem_q;
        wt_d    = wt_q;
        lsb_d   = lsb_q;
        out_d   = out_q;
        cnt_d   = cnt_q;

        if (start) begin
            if (mod_in == '0) begin
                state_d = StErr;
                n_d     = '0;
                rem_d   = '0;
                wt_d    = '0;
                out_d   = 1'b0;
                cnt_d   = '0;
            end else begin
                state_d = StRun;
                n_d     = mod_in;
                lsb_d   = lsb_first;
                if (in_valid) begin
                    rem_d = rem_step;
                    out_d = (rem_step == '0);
                    cnt_d = CNT_W'(1);
                    wt_d  = lsb_first ? wt_step : wt_init;
                end else begin
                    rem_d = '0;
                    out_d = 1'b0;
                    cnt_d = '0;
                    wt_d  = wt_init;
                end
            end
        end else if (state_q == StRun && in_valid) begin
            rem_d = rem_step;
            out_d = (rem_step == '0);
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            if (lsb_q) begin
                wt_d = wt_step;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            n_q     <= '0;
            rem_q   <= '0;
            wt_q    <= '0;
            lsb_q   <= 1'b0;
            out_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            rem_q   <= rem_d;
            wt_q    <= wt_d;
            lsb_q   <= lsb_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out       = out_q;
    assign rem       = rem_q;
    assign bit_count = cnt_q;
    assign busy      = (state_q == StRun);
    assign err       = (state_q == StErr);

endmodule
